// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: bus widths, the long-opcode flag position and the fetch FSM states.
package cpu_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 8;
   localparam int LONG_BIT = 7;

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_ARG = 2'd1,
      VALID     = 2'd2,
      HALTED    = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: reset value, load from a redirect target, or increment with natural wrap.
module pc_reg #(
   parameter int ADDR_W   = 5,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   // PC update; a load always wins over an increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= ADDR_W'(RESET_PC);
      end else if (load) begin
         pc <= load_addr;
      end else if (inc) begin
         pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         pc <= pc;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: assembles 1/2-byte instructions from memory and hands them to the decoder.
// Optional stall counter output enabled with macro IFU_STALL_COUNT_EN.
module instr_fetch_unit #(
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int RESET_PC = 0,
   parameter int LONG_BIT = cpu_pkg::LONG_BIT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic              r_w,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic [DATA_W-1:0] instr_opcode,
   output logic [DATA_W-1:0] instr_operand,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_addr,
   input  logic              halt,
   output logic              halted
`ifdef IFU_STALL_COUNT_EN
   ,
   output logic [15:0]       stall_count
`endif
);

   import cpu_pkg::*;

   fetch_state_e      state_r;
   fetch_state_e      next_state_s;
   logic [ADDR_W-1:0] pc_r;
   logic              pc_load_s;
   logic              pc_inc_s;
   logic              cap_op_s;
   logic              cap_arg_s;
   logic              valid_next_s;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (pc_load_s),
      .load_addr (jmp_addr),
      .inc       (pc_inc_s),
      .pc        (pc_r)
   );

   assign mem_addr_out = pc_r;
   assign r_w          = (state_r != HALTED);

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= FETCH_OP;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state and datapath strobes; a jump pre-empts capture, handshake and halt.
   always_comb begin
      next_state_s = state_r;
      pc_load_s    = 1'b0;
      pc_inc_s     = 1'b0;
      cap_op_s     = 1'b0;
      cap_arg_s    = 1'b0;
      valid_next_s = instr_valid;
      if (jmp_en) begin
         pc_load_s    = 1'b1;
         valid_next_s = 1'b0;
         if ((state_r == HALTED) && halt) begin
            next_state_s = HALTED;
         end else begin
            next_state_s = FETCH_OP;
         end
      end else begin
         case (state_r)
            FETCH_OP: begin
               if (halt) begin
                  next_state_s = HALTED;
               end else begin
                  cap_op_s = 1'b1;
                  pc_inc_s = 1'b1;
                  if (mem_data_out[LONG_BIT]) begin
                     next_state_s = FETCH_ARG;
                  end else begin
                     next_state_s = VALID;
                     valid_next_s = 1'b1;
                  end
               end
            end
            FETCH_ARG: begin
               cap_arg_s    = 1'b1;
               pc_inc_s     = 1'b1;
               next_state_s = VALID;
               valid_next_s = 1'b1;
            end
            VALID: begin
               if (instr_ready) begin
                  valid_next_s = 1'b0;
                  next_state_s = halt ? HALTED : FETCH_OP;
               end else begin
                  next_state_s = VALID;
               end
            end
            HALTED: begin
               if (!halt) begin
                  next_state_s = FETCH_OP;
               end else begin
                  next_state_s = HALTED;
               end
            end
            default: begin
               next_state_s = FETCH_OP;
               valid_next_s = 1'b0;
            end
         endcase
      end
   end

   // Instruction output registers; operand is zeroed at opcode capture and filled in for long opcodes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_opcode  <= {DATA_W{1'b0}};
         instr_operand <= {DATA_W{1'b0}};
         instr_pc      <= {ADDR_W{1'b0}};
         instr_valid   <= 1'b0;
         halted        <= 1'b0;
      end else begin
         if (cap_op_s) begin
            instr_opcode  <= mem_data_out;
            instr_operand <= {DATA_W{1'b0}};
            instr_pc      <= pc_r;
         end else if (cap_arg_s) begin
            instr_operand <= mem_data_out;
         end
         instr_valid <= valid_next_s;
         halted      <= (next_state_s == HALTED);
      end
   end

`ifdef IFU_STALL_COUNT_EN
   // Saturating count of cycles the decoder leaves a valid instruction waiting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= 16'h0000;
      end else if (jmp_en) begin
         stall_count <= 16'h0000;
      end else if (instr_valid && !instr_ready && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run against an
// instruction-stream reference model (expected pc advanced by instruction length, reset by jumps).
module tb_instr_fetch_unit;

   logic       clk;
   logic       reset;
   logic [4:0] mem_addr_out;
   logic       r_w;
   logic [7:0] mem_data_out;
   logic [7:0] instr_opcode;
   logic [7:0] instr_operand;
   logic [4:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       jmp_en;
   logic [4:0] jmp_addr;
   logic       halt;
   logic       halted;
`ifdef IFU_STALL_COUNT_EN
   logic [15:0] stall_count;
`endif

   logic [7:0] mem [32];
   int errors;
   int checks;

   assign mem_data_out = mem[mem_addr_out];

   instr_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .mem_addr_out  (mem_addr_out),
      .r_w           (r_w),
      .mem_data_out  (mem_data_out),
      .instr_opcode  (instr_opcode),
      .instr_operand (instr_operand),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .jmp_en        (jmp_en),
      .jmp_addr      (jmp_addr),
      .halt          (halt),
      .halted        (halted)
`ifdef IFU_STALL_COUNT_EN
      ,
      .stall_count   (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_jump(input logic [4:0] a);
      jmp_addr = a;
      jmp_en   = 1'b1;
      tick();
      jmp_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b0, 8'h00, 8'h00, 5'd0}) begin
         errors++;
         $display("FAIL reset_instr: got %h expected %h",
                  {instr_valid, instr_opcode, instr_operand, instr_pc}, {1'b0, 8'h00, 8'h00, 5'd0});
      end
      checks++;
      if ({halted, r_w, mem_addr_out} !== {1'b0, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL reset_ctrl: got halted=%b r_w=%b addr=%0d expected 0 1 0", halted, r_w, mem_addr_out);
      end
   endtask

   task automatic test_short_fetch();
      instr_ready = 1'b1;
      reset       = 1'b1;
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out} !==
          {1'b1, 8'h1F, 8'h00, 5'd0, 5'd1}) begin
         errors++;
         $display("FAIL short_first: got v=%b op=%h od=%h pc=%0d addr=%0d expected 1 1f 00 0 1",
                  instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL short_accept_drop: got valid=%b expected 0", instr_valid);
      end
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, 8'h1E, 8'h00, 5'd1}) begin
         errors++;
         $display("FAIL short_second: got v=%b op=%h od=%h pc=%0d expected 1 1e 00 1",
                  instr_valid, instr_opcode, instr_operand, instr_pc);
      end
      tick();
   endtask

   task automatic test_long_jump();
      instr_ready = 1'b0;
      mem[4] = 8'h85;
      mem[5] = 8'h3C;
      do_jump(5'd4);
      checks++;
      if ({instr_valid, mem_addr_out} !== {1'b0, 5'd4}) begin
         errors++;
         $display("FAIL jump_load: got valid=%b addr=%0d expected 0 4", instr_valid, mem_addr_out);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL long_arg_phase: got valid=%b expected 0", instr_valid);
      end
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out} !==
          {1'b1, 8'h85, 8'h3C, 5'd4, 5'd6}) begin
         errors++;
         $display("FAIL long_instr: got v=%b op=%h od=%h pc=%0d addr=%0d expected 1 85 3c 4 6",
                  instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out} !==
             {1'b1, 8'h85, 8'h3C, 5'd4, 5'd6}) begin
            errors++;
            $display("FAIL stall_stable[%0d]: got v=%b op=%h od=%h pc=%0d addr=%0d expected 1 85 3c 4 6",
                     i, instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out);
         end
      end
`ifdef IFU_STALL_COUNT_EN
      checks++;
      if (stall_count !== 16'd5) begin
         errors++;
         $display("FAIL stall_count: got %0d expected 5", stall_count);
      end
`endif
      instr_ready = 1'b1;
      tick();
      checks++;
      if ({instr_valid, mem_addr_out} !== {1'b0, 5'd6}) begin
         errors++;
         $display("FAIL stall_release: got valid=%b addr=%0d expected 0 6", instr_valid, mem_addr_out);
      end
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_pc} !== {1'b1, 8'h19, 5'd6}) begin
         errors++;
         $display("FAIL after_long_fetch: got v=%b op=%h pc=%0d expected 1 19 6",
                  instr_valid, instr_opcode, instr_pc);
      end
      tick();
   endtask

   task automatic test_wrap();
      instr_ready = 1'b0;
      mem[31] = 8'h90;
      mem[0]  = 8'h11;
      do_jump(5'd31);
      tick();
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out} !==
          {1'b1, 8'h90, 8'h11, 5'd31, 5'd1}) begin
         errors++;
         $display("FAIL wrap_instr: got v=%b op=%h od=%h pc=%0d addr=%0d expected 1 90 11 31 1",
                  instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out);
      end
      instr_ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, 8'h1E, 8'h00, 5'd1}) begin
         errors++;
         $display("FAIL wrap_next: got v=%b op=%h od=%h pc=%0d expected 1 1e 00 1",
                  instr_valid, instr_opcode, instr_operand, instr_pc);
      end
      tick();
   endtask

   task automatic test_halt();
      instr_ready = 1'b0;
      do_jump(5'd2);
      tick();
      checks++;
      if ({instr_valid, instr_pc, mem_addr_out} !== {1'b1, 5'd2, 5'd3}) begin
         errors++;
         $display("FAIL halt_setup: got v=%b pc=%0d addr=%0d expected 1 2 3", instr_valid, instr_pc, mem_addr_out);
      end
      halt = 1'b1;
      tick();
      checks++;
      if ({instr_valid, halted} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL halt_pending: got valid=%b halted=%b expected 1 0", instr_valid, halted);
      end
      instr_ready = 1'b1;
      tick();
      checks++;
      if ({instr_valid, halted, r_w, mem_addr_out} !== {1'b0, 1'b1, 1'b0, 5'd3}) begin
         errors++;
         $display("FAIL halt_enter: got valid=%b halted=%b r_w=%b addr=%0d expected 0 1 0 3",
                  instr_valid, halted, r_w, mem_addr_out);
      end
      repeat (3) tick();
      checks++;
      if ({halted, r_w, mem_addr_out} !== {1'b1, 1'b0, 5'd3}) begin
         errors++;
         $display("FAIL halt_hold: got halted=%b r_w=%b addr=%0d expected 1 0 3", halted, r_w, mem_addr_out);
      end
      halt = 1'b0;
      tick();
      checks++;
      if ({halted, r_w, mem_addr_out} !== {1'b0, 1'b1, 5'd3}) begin
         errors++;
         $display("FAIL halt_exit: got halted=%b r_w=%b addr=%0d expected 0 1 3", halted, r_w, mem_addr_out);
      end
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, 8'h1C, 8'h00, 5'd3}) begin
         errors++;
         $display("FAIL halt_resume: got v=%b op=%h od=%h pc=%0d expected 1 1c 00 3",
                  instr_valid, instr_opcode, instr_operand, instr_pc);
      end
   endtask

   task automatic test_jump_halted();
      halt = 1'b1;
      tick();
      do_jump(5'd10);
      checks++;
      if ({halted, r_w, mem_addr_out} !== {1'b1, 1'b0, 5'd10}) begin
         errors++;
         $display("FAIL jump_in_halt: got halted=%b r_w=%b addr=%0d expected 1 0 10", halted, r_w, mem_addr_out);
      end
      halt = 1'b0;
      tick();
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_pc, halted} !== {1'b1, 8'h15, 5'd10, 1'b0}) begin
         errors++;
         $display("FAIL jump_halt_resume: got v=%b op=%h pc=%0d halted=%b expected 1 15 10 0",
                  instr_valid, instr_opcode, instr_pc, halted);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      instr_ready = 1'b0;
      do_jump(5'd4);
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_pc} !== {1'b0, 8'h85, 5'd4}) begin
         errors++;
         $display("FAIL mid_setup: got v=%b op=%h pc=%0d expected 0 85 4", instr_valid, instr_opcode, instr_pc);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc, halted, r_w, mem_addr_out} !==
          {1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL mid_reset: got v=%b op=%h od=%h pc=%0d halted=%b r_w=%b addr=%0d expected all reset",
                  instr_valid, instr_opcode, instr_operand, instr_pc, halted, r_w, mem_addr_out);
      end
      tick();
      reset       = 1'b1;
      instr_ready = 1'b1;
      tick();
      checks++;
      if ({instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out} !==
          {1'b1, 8'h11, 8'h00, 5'd0, 5'd1}) begin
         errors++;
         $display("FAIL mid_refetch: got v=%b op=%h od=%h pc=%0d addr=%0d expected 1 11 00 0 1",
                  instr_valid, instr_opcode, instr_operand, instr_pc, mem_addr_out);
      end
   endtask

   task automatic test_random();
      int         exp_pc;
      int         idle;
      int         a;
      logic       pv;
      logic       rdy;
      logic       j;
      logic [7:0] pop;
      logic [7:0] pod;
      logic [4:0] ppc;
      logic [7:0] e_op;
      logic [7:0] e_od;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      halt        = 1'b0;
      instr_ready = 1'b0;
      a = $urandom_range(0, 31);
      do_jump(5'(a));
      exp_pc = a;
      idle   = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         pv  = instr_valid;
         pop = instr_opcode;
         pod = instr_operand;
         ppc = instr_pc;
         rdy = ($urandom_range(0, 3) != 0);
         j   = ($urandom_range(0, 19) == 0);
         a   = $urandom_range(0, 31);
         instr_ready = rdy;
         jmp_en      = j;
         jmp_addr    = 5'(a);
         tick();
         jmp_en = 1'b0;
         if (pv && rdy) begin
            e_op = mem[exp_pc];
            e_od = e_op[7] ? mem[(exp_pc + 1) % 32] : 8'h00;
            checks++;
            if ({pop, pod, ppc} !== {e_op, e_od, 5'(exp_pc)}) begin
               errors++;
               $display("FAIL rand_instr: got op=%h od=%h pc=%0d expected op=%h od=%h pc=%0d",
                        pop, pod, ppc, e_op, e_od, exp_pc);
            end
            exp_pc = (exp_pc + (e_op[7] ? 2 : 1)) % 32;
            idle   = 0;
         end else if (pv && !j) begin
            checks++;
            if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, pop, pod, ppc}) begin
               errors++;
               $display("FAIL rand_stable: got v=%b op=%h od=%h pc=%0d expected 1 %h %h %0d",
                        instr_valid, instr_opcode, instr_operand, instr_pc, pop, pod, ppc);
            end
            idle++;
         end else begin
            idle++;
         end
         if (j) begin
            exp_pc = a;
            idle   = 0;
         end
         if (idle > 40) begin
            checks++;
            errors++;
            $display("FAIL rand_timeout: got no accepted instruction in %0d cycles expected at most 40", idle);
            break;
         end
      end
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      instr_ready = 1'b1;
      jmp_en      = 1'b0;
      jmp_addr    = 5'd0;
      halt        = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 8'(31 - i);
      test_reset();
      test_short_fetch();
      test_long_jump();
      test_stall();
      test_wrap();
      test_halt();
      test_jump_halted();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
